// File: rtl/lab3_mem_line_to_word_adapter.sv
// lab3_mem_line_to_word_adapter
//
// Converts one cacheline memory request from the blocking cache into four
// word requests to a word-wide memory. It then gathers the four word
// responses and returns a single cacheline response. Word issue and response
// collection run concurrently, so up to four word requests can be in flight.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   memreq_*              line request from the cache (val/rdy, type, opaque,
//                         addr, 128-bit data)
//   memresp_*             line response to the cache (val/rdy, type, opaque,
//                         128-bit data)
//   wmemreq_*             word request to memory (val/rdy, type, opaque =
//                         word index, addr, 32-bit data)
//   wmemresp_*            word response from memory (val/rdy, opaque, data)
module lab3_mem_line_to_word_adapter #(
    parameter int p_opaque_nbits = 8,
    parameter int p_line_nbits   = 128,
    parameter int p_word_nbits   = 32
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      memreq_val,
    output logic                      memreq_rdy,
    input  logic [2:0]                memreq_type,
    input  logic [p_opaque_nbits-1:0] memreq_opaque,
    input  logic [31:0]               memreq_addr,
    input  logic [p_line_nbits-1:0]   memreq_data,

    output logic                      memresp_val,
    input  logic                      memresp_rdy,
    output logic [2:0]                memresp_type,
    output logic [p_opaque_nbits-1:0] memresp_opaque,
    output logic [p_line_nbits-1:0]   memresp_data,

    output logic                      wmemreq_val,
    input  logic                      wmemreq_rdy,
    output logic [2:0]                wmemreq_type,
    output logic [p_opaque_nbits-1:0] wmemreq_opaque,
    output logic [31:0]               wmemreq_addr,
    output logic [p_word_nbits-1:0]   wmemreq_data,

    input  logic                      wmemresp_val,
    output logic                      wmemresp_rdy,
    input  logic [p_opaque_nbits-1:0] wmemresp_opaque,
    input  logic [p_word_nbits-1:0]   wmemresp_data
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t                    state, state_next;
    logic [2:0]                type_q;
    logic [p_opaque_nbits-1:0] opaque_q;
    logic [27:0]               addr_q;
    logic [p_line_nbits-1:0]   wdata_q;
    logic [p_line_nbits-1:0]   line_q;
    logic [2:0]                ic_q;   // word requests issued
    logic [2:0]                rc_q;   // word responses collected

    logic req_fire, iss_fire, rsp_fire, is_write;

    assign req_fire = memreq_val && memreq_rdy;
    assign iss_fire = wmemreq_val && wmemreq_rdy;
    assign rsp_fire = wmemresp_val && wmemresp_rdy;
    // Any type other than write (including illegal ones) behaves as a read.
    assign is_write = (type_q == 3'd1);

    // Low address bits select a byte within the line and are not needed.
    logic unused_bits;
    assign unused_bits = ^{memreq_addr[3:0], wmemresp_opaque[p_opaque_nbits-1:2]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (memreq_val) state_next = XFER;
            // Leave XFER on the same edge that collects the last word, so
            // RESP is visible in the cycle after rc reaches 4.
            XFER: if (rsp_fire && rc_q == 3'd3) state_next = RESP;
            RESP: if (memresp_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; handshake outputs depend only on registered state.
    always_comb begin
        memreq_rdy   = 1'b0;
        wmemreq_val  = 1'b0;
        wmemresp_rdy = 1'b0;
        memresp_val  = 1'b0;
        memresp_data = '0;
        case (state)
            IDLE: memreq_rdy = reset;
            XFER: begin
                wmemreq_val  = (ic_q < 3'd4);
                // rc < ic keeps a response from being taken before its request.
                wmemresp_rdy = (rc_q < 3'd4) && (rc_q < ic_q);
            end
            RESP: begin
                memresp_val  = 1'b1;
                memresp_data = is_write ? '0 : line_q;
            end
            default: ;
        endcase
    end

    assign memresp_type   = type_q;
    assign memresp_opaque = opaque_q;
    assign wmemreq_type   = type_q;
    assign wmemreq_opaque = {{(p_opaque_nbits-2){1'b0}}, ic_q[1:0]};
    assign wmemreq_addr   = {addr_q, 4'b0000} + {27'b0, ic_q, 2'b00};
    assign wmemreq_data   = wdata_q[ic_q[1:0]*p_word_nbits +: p_word_nbits];

    // Request latch, issue/collect counters and line assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_q   <= '0;
            opaque_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            ic_q     <= '0;
            rc_q     <= '0;
        end else if (req_fire) begin
            type_q   <= memreq_type;
            opaque_q <= memreq_opaque;
            addr_q   <= memreq_addr[31:4];
            wdata_q  <= memreq_data;
            line_q   <= '0;
            ic_q     <= '0;
            rc_q     <= '0;
        end else begin
            // Both fires are gated by count < 4, so the counters saturate.
            if (iss_fire) ic_q <= ic_q + 3'd1;
            if (rsp_fire) begin
                if (!is_write)
                    line_q[rc_q[1:0]*p_word_nbits +: p_word_nbits] <= wmemresp_data;
                rc_q <= rc_q + 3'd1;
            end
        end
    end

    // Simulation-only sanity checks on request type and response ordering.
    always @(posedge clk) begin
        if (reset && req_fire)
            assert (memreq_type == 3'd0 || memreq_type == 3'd1);
        if (reset && rsp_fire)
            assert (wmemresp_opaque[1:0] == rc_q[1:0]);
    end

endmodule

// File: tb/tb_lab3_mem_line_to_word_adapter.sv
// Testbench for lab3_mem_line_to_word_adapter: a behavioural word memory with
// adjustable latency and request backpressure, plus directed scenario tasks.
module tb_lab3_mem_line_to_word_adapter;

    logic         clk = 1'b0;
    logic         reset;
    logic         memreq_val;
    logic         memreq_rdy;
    logic [2:0]   memreq_type;
    logic [7:0]   memreq_opaque;
    logic [31:0]  memreq_addr;
    logic [127:0] memreq_data;
    logic         memresp_val;
    logic         memresp_rdy;
    logic [2:0]   memresp_type;
    logic [7:0]   memresp_opaque;
    logic [127:0] memresp_data;
    logic         wmemreq_val;
    logic         wmemreq_rdy;
    logic [2:0]   wmemreq_type;
    logic [7:0]   wmemreq_opaque;
    logic [31:0]  wmemreq_addr;
    logic [31:0]  wmemreq_data;
    logic         wmemresp_val;
    logic         wmemresp_rdy;
    logic [7:0]   wmemresp_opaque;
    logic [31:0]  wmemresp_data;

    always #5 clk = ~clk;

    lab3_mem_line_to_word_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_type     (memreq_type),
        .memreq_opaque   (memreq_opaque),
        .memreq_addr     (memreq_addr),
        .memreq_data     (memreq_data),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_type    (memresp_type),
        .memresp_opaque  (memresp_opaque),
        .memresp_data    (memresp_data),
        .wmemreq_val     (wmemreq_val),
        .wmemreq_rdy     (wmemreq_rdy),
        .wmemreq_type    (wmemreq_type),
        .wmemreq_opaque  (wmemreq_opaque),
        .wmemreq_addr    (wmemreq_addr),
        .wmemreq_data    (wmemreq_data),
        .wmemresp_val    (wmemresp_val),
        .wmemresp_rdy    (wmemresp_rdy),
        .wmemresp_opaque (wmemresp_opaque),
        .wmemresp_data   (wmemresp_data)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mem_lat = 1;          // response valid mem_lat cycles after request accept
    bit rdy_toggle = 1'b0;    // alternate wmemreq_rdy every cycle when set
    logic prev_val = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  op;
        int          due;
    } pend_t;
    pend_t pend[$];

    logic [31:0]  iss_addr[$];
    logic [31:0]  iss_data[$];
    logic [2:0]   iss_type[$];
    logic [7:0]   iss_op[$];
    int           iss_cyc[$];
    int           wrsp_cyc[$];
    int           req_cyc[$];
    int           val_cyc[$];
    logic [2:0]   rsp_type[$];
    logic [7:0]   rsp_op[$];
    logic [127:0] rsp_data[$];
    int           rsp_cyc[$];

    // Initial memory image: 0xA0..0xA3 at 0x1230..0x123C, else addr ^ 0xC0DE0000.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h1230 && a <= 32'h123C) return 32'hA0 + ((a - 32'h1230) >> 2);
        return a ^ 32'hC0DE0000;
    endfunction

    // Current memory contents: latest accepted word write wins.
    function automatic logic [31:0] lookup(input logic [31:0] a);
        for (int i = iss_addr.size() - 1; i >= 0; i--)
            if (iss_type[i] == 3'd1 && iss_addr[i] == a) return iss_data[i];
        return init_word(a);
    endfunction

    // Observe handshakes on the clock edge; memory state lives here.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_val <= memresp_val;
        if (!reset) begin
            pend.delete();
        end else begin
            if (wmemresp_val && wmemresp_rdy) begin
                wrsp_cyc.push_back(cyc);
                void'(pend.pop_front());
            end
            if (wmemreq_val && wmemreq_rdy) begin
                pend.push_back(pend_t'{data: (wmemreq_type == 3'd1) ? 32'h0 : lookup(wmemreq_addr),
                                       op: wmemreq_opaque, due: cyc + mem_lat});
                iss_addr.push_back(wmemreq_addr);
                iss_data.push_back(wmemreq_data);
                iss_type.push_back(wmemreq_type);
                iss_op.push_back(wmemreq_opaque);
                iss_cyc.push_back(cyc);
            end
            if (memreq_val && memreq_rdy) req_cyc.push_back(cyc);
            if (memresp_val && !prev_val) val_cyc.push_back(cyc);
            if (memresp_val && memresp_rdy) begin
                rsp_type.push_back(memresp_type);
                rsp_op.push_back(memresp_opaque);
                rsp_data.push_back(memresp_data);
                rsp_cyc.push_back(cyc);
            end
        end
    end

    // Memory outputs change on the falling edge only.
    always @(negedge clk) begin
        if (rdy_toggle) wmemreq_rdy <= !wmemreq_rdy;
        else            wmemreq_rdy <= 1'b1;
        if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
            wmemresp_val    <= 1'b1;
            wmemresp_data   <= pend[0].data;
            wmemresp_opaque <= pend[0].op;
        end else begin
            wmemresp_val    <= 1'b0;
            wmemresp_data   <= 32'h0;
            wmemresp_opaque <= 8'h0;
        end
    end

    task automatic send_req(input logic [2:0] t, input logic [7:0] op,
                            input logic [31:0] a, input logic [127:0] d);
        int n = 0;
        @(negedge clk);
        memreq_val    = 1'b1;
        memreq_type   = t;
        memreq_opaque = op;
        memreq_addr   = a;
        memreq_data   = d;
        while (!memreq_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (memreq_rdy !== 1'b1) begin
            fails++;
            $display("FAIL req_accept: memreq_rdy=%b required 1 within 100 cycles", memreq_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        memreq_val = 1'b0;
    endtask

    task automatic wait_resps(input int target, input string name);
        int k = 0;
        while (rsp_op.size() < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (rsp_op.size() < target) begin
            fails++;
            $display("FAIL %s_timeout: responses=%0d required %0d", name, rsp_op.size(), target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        memreq_val = 1'b0; memreq_type = 3'd0; memreq_opaque = 8'h0;
        memreq_addr = 32'h0; memreq_data = 128'h0; memresp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hs: rdy/val={%b%b%b%b} required 0000",
                     memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy);
        end
        tests++;
        if (memresp_data !== 128'h0 || wmemreq_data !== 32'h0 || wmemreq_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: memresp_data=%h wmemreq_data=%h wmemreq_addr=%h required 0",
                     memresp_data, wmemreq_data, wmemreq_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (memreq_rdy !== 1'b1 || wmemreq_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: memreq_rdy=%b wmemreq_val=%b required 1 0",
                     memreq_rdy, wmemreq_val);
        end
    endtask

    task automatic test_refill_read();
        logic [31:0] exp_a[4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        int bi = iss_addr.size(), br = rsp_op.size(), bq = req_cyc.size();
        int bv = val_cyc.size(), bw = wrsp_cyc.size(), c0;
        mem_lat = 1; rdy_toggle = 1'b0; memresp_rdy = 1'b1;
        send_req(3'd0, 8'h5A, 32'h00001234, 128'h0);
        wait_resps(br + 1, "refill");
        c0 = req_cyc[bq];
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (iss_addr[bi+i] !== exp_a[i] || iss_type[bi+i] !== 3'd0 ||
                iss_op[bi+i] !== 8'(i) || iss_cyc[bi+i] !== c0 + 1 + i) begin
                fails++;
                $display("FAIL refill_issue%0d: addr=%h type=%0d op=%0d cyc=%0d required %h 0 %0d %0d",
                         i, iss_addr[bi+i], iss_type[bi+i], iss_op[bi+i], iss_cyc[bi+i] - c0,
                         exp_a[i], i, 1 + i);
            end
            tests++;
            if (wrsp_cyc[bw+i] !== c0 + 2 + i) begin
                fails++;
                $display("FAIL refill_wresp%0d: cycle=%0d required %0d", i, wrsp_cyc[bw+i] - c0, 2 + i);
            end
        end
        tests++;
        if (val_cyc[bv] !== c0 + 6) begin
            fails++;
            $display("FAIL refill_latency: memresp_val at cycle %0d required 6", val_cyc[bv] - c0);
        end
        tests++;
        if (rsp_type[br] !== 3'd0 || rsp_op[br] !== 8'h5A ||
            rsp_data[br] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            fails++;
            $display("FAIL refill_resp: type=%0d op=%h data=%h required 0 5a 000000a3000000a2000000a1000000a0",
                     rsp_type[br], rsp_op[br], rsp_data[br]);
        end
    endtask

    task automatic test_evict_write();
        logic [31:0] exp_a[4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        logic [31:0] exp_d[4] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};
        int bi = iss_addr.size(), br = rsp_op.size();
        mem_lat = 1; rdy_toggle = 1'b0; memresp_rdy = 1'b1;
        send_req(3'd1, 8'h33, 32'h00002000, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA);
        wait_resps(br + 1, "evict");
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (iss_addr[bi+i] !== exp_a[i] || iss_data[bi+i] !== exp_d[i] || iss_type[bi+i] !== 3'd1) begin
                fails++;
                $display("FAIL evict_issue%0d: addr=%h data=%h type=%0d required %h %h 1",
                         i, iss_addr[bi+i], iss_data[bi+i], iss_type[bi+i], exp_a[i], exp_d[i]);
            end
        end
        tests++;
        if (rsp_type[br] !== 3'd1 || rsp_op[br] !== 8'h33 || rsp_data[br] !== 128'h0) begin
            fails++;
            $display("FAIL evict_resp: type=%0d op=%h data=%h required 1 33 0",
                     rsp_type[br], rsp_op[br], rsp_data[br]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  exp_a[4] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        logic [127:0] exp_line = 128'hC0DE400C_C0DE4008_C0DE4004_C0DE4000;
        int bi = iss_addr.size(), br = rsp_op.size(), k = 0;
        mem_lat = 1; rdy_toggle = 1'b1; memresp_rdy = 1'b0;
        send_req(3'd0, 8'h11, 32'h00004000, {4{32'hFFFF_FFFF}});
        while (memresp_val !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int s = 0; s < 5; s++) begin
            tests++;
            if (memresp_val !== 1'b1 || memresp_type !== 3'd0 || memresp_opaque !== 8'h11 ||
                memresp_data !== exp_line) begin
                fails++;
                $display("FAIL bp_stall%0d: val=%b type=%0d op=%h data=%h required 1 0 11 %h",
                         s, memresp_val, memresp_type, memresp_opaque, memresp_data, exp_line);
            end
            @(negedge clk);
        end
        tests++;
        if (rsp_op.size() !== br) begin
            fails++;
            $display("FAIL bp_no_early_resp: responses=%0d required %0d", rsp_op.size(), br);
        end
        memresp_rdy = 1'b1;
        @(negedge clk);
        memresp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (rsp_op.size() !== br + 1 || iss_addr.size() !== bi + 4 || memresp_val !== 1'b0) begin
            fails++;
            $display("FAIL bp_counts: responses=%0d issues=%0d memresp_val=%b required %0d %0d 0",
                     rsp_op.size() - br, iss_addr.size() - bi, memresp_val, 1, 4);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (iss_addr[bi+i] !== exp_a[i]) begin
                fails++;
                $display("FAIL bp_issue%0d: addr=%h required %h", i, iss_addr[bi+i], exp_a[i]);
            end
        end
        tests++;
        if (rsp_data[br] !== exp_line || rsp_op[br] !== 8'h11) begin
            fails++;
            $display("FAIL bp_resp: op=%h data=%h required 11 %h", rsp_op[br], rsp_data[br], exp_line);
        end
        rdy_toggle = 1'b0;
        memresp_rdy = 1'b1;
    endtask

    task automatic test_overlap();
        int br = rsp_op.size(), k = 0, maxo = 0;
        mem_lat = 4; rdy_toggle = 1'b0; memresp_rdy = 1'b1;
        send_req(3'd0, 8'h77, 32'h00001230, 128'h0);
        while (rsp_op.size() < br + 1 && k < 100) begin
            @(negedge clk);
            if (pend.size() > maxo) maxo = pend.size();
            k++;
        end
        tests++;
        if (maxo !== 4) begin
            fails++;
            $display("FAIL overlap_outstanding: max=%0d required 4", maxo);
        end
        tests++;
        if (rsp_op[br] !== 8'h77 || rsp_data[br] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            fails++;
            $display("FAIL overlap_resp: op=%h data=%h required 77 000000a3000000a2000000a1000000a0",
                     rsp_op[br], rsp_data[br]);
        end
        mem_lat = 1;
    endtask

    task automatic test_reset_mid_xfer();
        int bi = iss_addr.size(), br = rsp_op.size(), k = 0, bi2;
        mem_lat = 1; rdy_toggle = 1'b0; memresp_rdy = 1'b1;
        send_req(3'd0, 8'h42, 32'h00006000, 128'h0);
        while (iss_addr.size() < bi + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_outputs: rdy/val={%b%b%b%b} required 0000",
                     memreq_rdy, memresp_val, wmemreq_val, wmemresp_rdy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0 || rsp_op.size() !== br) begin
            fails++;
            $display("FAIL midrst_release: memreq_rdy=%b memresp_val=%b responses=%0d required 1 0 0",
                     memreq_rdy, memresp_val, rsp_op.size() - br);
        end
        bi2 = iss_addr.size();
        send_req(3'd0, 8'h43, 32'h00007000, 128'h0);
        wait_resps(br + 1, "midrst");
        tests++;
        if (rsp_op[br] !== 8'h43 || rsp_data[br] !== 128'hC0DE700C_C0DE7008_C0DE7004_C0DE7000 ||
            iss_addr.size() !== bi2 + 4) begin
            fails++;
            $display("FAIL midrst_fresh: op=%h data=%h issues=%0d required 43 c0de700cc0de7008c0de7004c0de7000 4",
                     rsp_op[br], rsp_data[br], iss_addr.size() - bi2);
        end
    endtask

    task automatic test_back_to_back();
        int br = rsp_op.size(), bq = req_cyc.size();
        mem_lat = 1; rdy_toggle = 1'b0; memresp_rdy = 1'b1;
        send_req(3'd0, 8'h81, 32'h00008000, 128'h0);
        send_req(3'd1, 8'h82, 32'h00009000, 128'h44444444_33333333_22222222_11111111);
        wait_resps(br + 2, "b2b");
        tests++;
        if (req_cyc[bq+1] !== rsp_cyc[br] + 1) begin
            fails++;
            $display("FAIL b2b_accept: second accept %0d cycles after first response required 1",
                     req_cyc[bq+1] - rsp_cyc[br]);
        end
        tests++;
        if (rsp_op[br] !== 8'h81 || rsp_type[br] !== 3'd0 ||
            rsp_data[br] !== 128'hC0DE800C_C0DE8008_C0DE8004_C0DE8000) begin
            fails++;
            $display("FAIL b2b_first: op=%h type=%0d data=%h required 81 0 c0de800cc0de8008c0de8004c0de8000",
                     rsp_op[br], rsp_type[br], rsp_data[br]);
        end
        tests++;
        if (rsp_op[br+1] !== 8'h82 || rsp_type[br+1] !== 3'd1 || rsp_data[br+1] !== 128'h0) begin
            fails++;
            $display("FAIL b2b_second: op=%h type=%0d data=%h required 82 1 0",
                     rsp_op[br+1], rsp_type[br+1], rsp_data[br+1]);
        end
    endtask

    initial begin
        test_reset();
        test_refill_read();
        test_evict_write();
        test_backpressure();
        test_overlap();
        test_reset_mid_xfer();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
